// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: word-addressed RAM with a
// fixed access latency, stalling the pipeline while an access is outstanding.
module dmem_responder #(
   parameter int LATENCY = 3,
   parameter int WORDS   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid_i,
   input  logic        mem_ren_i,
   input  logic        mem_wen_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_din_i,
   output logic [31:0] mem_dout_o,
   output logic        mem_stall_o,
   output logic        addr_err_o,
   output logic        err_sticky_o,
   output logic [31:0] stall_count_o
);

   localparam int IDX_W = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        data_q, data_d;
   logic [31:0]        dout_q;
   logic               sticky_q;
   logic [31:0]        scount_q;
   logic               req;
   logic               aligned;
   logic               commit;
   logic               unusedAddrBits;

   logic [31:0] ram [WORDS];

   assign req            = mem_valid_i & (mem_ren_i | mem_wen_i);
   assign aligned        = (mem_addr_i[1:0] == 2'b00);
   assign addr_err_o     = req & ~aligned;
   // Upper address bits are deliberately dropped so accesses wrap modulo the RAM size.
   assign unusedAddrBits = ^mem_addr_i[31:IDX_W+2];

   assign mem_dout_o     = dout_q;
   assign err_sticky_o   = sticky_q;
   assign stall_count_o  = scount_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      idx_d       = idx_q;
      data_d      = data_q;
      commit      = 1'b0;
      mem_stall_o = 1'b0;
      case (state_q)
         IDLE: begin
            // Stall is raised in the accept cycle itself so MEM freezes before advancing.
            if (req && aligned) begin
               mem_stall_o = 1'b1;
               wr_d        = mem_wen_i;
               idx_d       = mem_addr_i[IDX_W+1:2];
               data_d      = mem_din_i;
               cnt_d       = 4'(LATENCY - 1);
               state_d     = BUSY;
            end
         end
         BUSY: begin
            mem_stall_o = 1'b1;
            if (cnt_q == 4'd0) begin
               commit  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         wr_q     <= 1'b0;
         idx_q    <= '0;
         data_q   <= 32'd0;
         dout_q   <= 32'd0;
         sticky_q <= 1'b0;
         scount_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         if (commit && !wr_q) dout_q <= ram[idx_q];
         if (addr_err_o) sticky_q <= 1'b1;
         if (mem_stall_o) scount_q <= scount_q + 32'd1;
      end
   end

   // RAM contents survive reset; a reset in the commit cycle suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && commit && wr_q) ram[idx_q] <= data_q;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the 5-stage MIPS pipeline. It sits at the MEM stage and services the `mem_ren`/`mem_wen` requests the pipeline controller decodes for LW/SW. It holds an internal word-addressed RAM with a configurable access latency. While an access is outstanding it raises `mem_stall` back to the pipeline controller, which freezes IF/ID/EXE/MEM and bubbles WB until the access completes.

## Interface
- `LATENCY`, 3: wait cycles per access; legal range 1..15.
- `WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `mem_valid` input 1: MEM stage valid flag.
- `mem_ren` input 1: read request (LW) from the MEM stage.
- `mem_wen` input 1: write request (SW) from the MEM stage.
- `mem_addr` input 32: byte address (ALU result).
- `mem_din` input 32: store data (forwarded rt).
- `mem_dout` output 32: load data; valid in the DONE cycle.
- `mem_stall` output 1: to the controller; while high, if/id/exe/mem `en` = 0 and `wb_rst` = 1.
- `addr_err` output 1: current request is misaligned (combinational).
- `err_sticky` output 1: latched flag, set on any `addr_err`.
- `stall_count` output 32: total cycles with `mem_stall` = 1.

## Operation
- Request: `req = mem_valid & (mem_ren | mem_wen)`.
- Operation select: if both `mem_ren` and `mem_wen` are high, the access is a write.
- Word index: `mem_addr[log2(WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `WORDS*4`.
- Misaligned request (`mem_addr[1:0] != 0`):
  - `addr_err` = 1; `err_sticky` is set.
  - No access and no stall; the instruction proceeds. Loads return the previous `mem_dout`.
- FSM states: IDLE, BUSY, DONE.
  - **IDLE:**
    - If `req` is high and the address is aligned: latch op, index and `mem_din`; load `cnt = LATENCY-1`; go to BUSY.
    - Otherwise stay in IDLE.
  - **BUSY:**
    - If `cnt == 0`: commit on this clock edge (write RAM, or register the read into `mem_dout`), then go to DONE.
    - Otherwise decrement `cnt`.
  - **DONE:**
    - `mem_stall` = 0, so the pipeline advances and MEM/WB captures `mem_dout`.
    - Always go to IDLE; the held request is not re-accepted.
- Stall: `mem_stall = (IDLE & req & aligned) | BUSY`. It is asserted combinationally in the accept cycle so the controller freezes MEM before the instruction moves on.
- Latched values: op, address and data are latched at accept. Input changes during BUSY are ignored.
- Writes to any index are legal, including index 0. Write-then-read of the same word returns the new data.
- `stall_count` increments every cycle in which `mem_stall` = 1. It wraps at 2^32.
- `cnt` is 4 bits wide.

## Timing
- Stall length: `mem_stall` is high for exactly LATENCY+1 consecutive cycles (the accept cycle plus LATENCY BUSY cycles). The DONE cycle follows.
- Commit point: write data is committed, and load data appears on `mem_dout`, at the edge entering DONE.
- Hold: `mem_dout` holds its value until the next read commit.
- Back-to-back accesses: a new request is seen in IDLE on the cycle after DONE. The inter-access gap is therefore one cycle (DONE) plus one cycle (IDLE accept).
- Non-memory instructions: no stall; all outputs except `addr_err` are static.
- Reset values:
  - State: IDLE; `cnt` = 0.
  - `mem_stall` = 0 in the cycle after reset, unless a request is already present.
  - `mem_dout` = 0; `err_sticky` = 0; `stall_count` = 0.
- Reset does not clear RAM contents.
- Reset mid-access (in BUSY): the pending write is discarded and the read is not delivered. The FSM is in IDLE at the next edge.
- Reset and commit in the same cycle: reset wins, and no RAM write occurs.
- `mem_valid` = 0: treated as no request, even if `ren`/`wen` are high.

## Test plan
- **Single load, LATENCY=3.** Preload word 4 = 0xDEADBEEF; LW at address 0x10.
  - `mem_stall` high for cycles 0–3.
  - Cycle 4 is DONE with `mem_dout` = 0xDEADBEEF and `mem_stall` = 0.
  - `stall_count` = 4.
- **SW then LW to the same address.** SW 0x12345678 to 0x20, then LW from 0x20.
  - Load returns 0x12345678.
  - Two stall windows of 4 cycles each, separated by DONE + IDLE.
  - `stall_count` = 8.
- **Misaligned store.** SW at 0x22.
  - `addr_err` = 1 that cycle; `err_sticky` = 1 afterwards.
  - `mem_stall` stays 0; word 8 is unchanged.
- **Reset mid-write.** SW 0xAAAA5555 to 0x40, with `rst` pulsed in BUSY (`cnt` = 1).
  - Next cycle: IDLE, `mem_stall` = 0.
  - A subsequent LW 0x40 returns the old contents.
- **LATENCY=1 boundary and address wrap.** With WORDS=1024, SW to 0x1004 then LW from 0x0004.
  - Each access stalls exactly 2 cycles.
  - Load returns the stored value.
- **ren and wen both high, then bubble.** Issue a request with both `ren` and `wen` high, followed by `mem_valid` = 0 with `ren` high.
  - The first is treated as a write.
  - The second causes no stall and no `stall_count` increment.
